// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: StallBus width,
// stall level encodings and register index width.
package pipe_hazard_ctrl_pkg;

  localparam int STALL_BUS_W = 6;
  localparam int REG_AW      = 5;
  localparam int NUM_REGS    = 32;
  localparam int RUN_W       = 16;

  localparam logic [STALL_BUS_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_BUS_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_BUS_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_BUS_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    LVL_NONE,
    LVL_ID,
    LVL_EX,
    LVL_MEM
  } stall_lvl_e;

  function automatic logic [STALL_BUS_W-1:0] stall_mask(input stall_lvl_e lvl);
    case (lvl)
      LVL_ID:  return STALL_ID;
      LVL_EX:  return STALL_EX;
      LVL_MEM: return STALL_MEM;
      default: return STALL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Per-register pending-writer counters for long-latency results (x0 never tracked),
// with two source read ports and a destination saturation read.
module pipe_hazard_ctrl_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc_en,
  input  logic [REG_AW-1:0] inc_idx,
  input  logic              dec_en,
  input  logic [REG_AW-1:0] dec_idx,
  input  logic [REG_AW-1:0] rd1_idx,
  input  logic [REG_AW-1:0] rd2_idx,
  input  logic [REG_AW-1:0] rdw_idx,
  output logic [CNT_W-1:0]  rd1_cnt,
  output logic [CNT_W-1:0]  rd2_cnt,
  output logic              rdw_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]    pend_reg [NUM_REGS];
  logic [NUM_REGS-1:0] inc_hit;
  logic [NUM_REGS-1:0] dec_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_hit
      if (gi == 0) begin : g_x0
        assign inc_hit[gi] = 1'b0;
        assign dec_hit[gi] = 1'b0;
      end else begin : g_reg
        assign inc_hit[gi] = inc_en && (inc_idx == REG_AW'(gi));
        assign dec_hit[gi] = dec_en && (dec_idx == REG_AW'(gi));
      end
    end
  endgenerate

  // Simultaneous issue and retire cancel; the guards stop wrap in either direction.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < NUM_REGS; i++) pend_reg[i] <= '0;
    end else begin
      pend_reg[0] <= '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (inc_hit[i] && dec_hit[i])
          pend_reg[i] <= pend_reg[i];
        else if (inc_hit[i] && (pend_reg[i] != CNT_MAX))
          pend_reg[i] <= pend_reg[i] + CNT_W'(1);
        else if (dec_hit[i] && (pend_reg[i] != '0))
          pend_reg[i] <= pend_reg[i] - CNT_W'(1);
      end
    end
  end

  assign rd1_cnt = (rd1_idx == '0) ? '0 : pend_reg[rd1_idx];
  assign rd2_cnt = (rd2_idx == '0) ? '0 : pend_reg[rd2_idx];
  assign rdw_sat = (rdw_idx != '0) && (pend_reg[rdw_idx] == CNT_MAX);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler: scoreboard hazards, StallBus priority encoding,
// stall watchdog and hazard-cycle performance counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int STALL_W  = 6,
  parameter int CNT_W    = 2,
  parameter int STALL_TO = 1024,
  parameter int PERF_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic               id_rf_we,
  input  logic [4:0]         id_rd,
  input  logic               id_long,
  input  logic               ret_valid,
  input  logic [4:0]         ret_rd,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  output logic [STALL_W-1:0] stall,
  output logic               stallreq_id,
  output logic               stall_timeout,
  output logic [PERF_W-1:0]  hazard_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             issue_base;
  logic             issue;
  logic             ret_dec;
  logic             raw1;
  logic             raw2;
  logic             wawsat;
  logic [CNT_W-1:0] cnt_rs1;
  logic [CNT_W-1:0] cnt_rs2;
  logic             sat_rd;
  stall_lvl_e       lvl;

  logic [RUN_W-1:0]  run_reg, run_next;
  logic              timeout_reg, timeout_next;
  logic [PERF_W-1:0] hazard_reg, hazard_next;

  pipe_hazard_ctrl_scoreboard #(
    .CNT_W (CNT_W)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .inc_en  (issue),
    .inc_idx (id_rd),
    .dec_en  (ret_dec),
    .dec_idx (ret_rd),
    .rd1_idx (id_rs1),
    .rd2_idx (id_rs2),
    .rdw_idx (id_rd),
    .rd1_cnt (cnt_rs1),
    .rd2_cnt (cnt_rs2),
    .rdw_sat (sat_rd)
  );

  // A last outstanding writer retiring this cycle is bypassed from WB, so no RAW.
  always_comb begin
    ret_dec     = ret_valid && (ret_rd != '0);
    issue_base  = id_valid && id_rf_we && id_long && (id_rd != '0) && !flush;
    raw1        = id_use_rs1 && (id_rs1 != '0) && (cnt_rs1 != '0) &&
                  !(ret_dec && (ret_rd == id_rs1) && (cnt_rs1 == CNT_ONE));
    raw2        = id_use_rs2 && (id_rs2 != '0) && (cnt_rs2 != '0) &&
                  !(ret_dec && (ret_rd == id_rs2) && (cnt_rs2 == CNT_ONE));
    wawsat      = issue_base && sat_rd;
    stallreq_id = id_valid && (raw1 || raw2 || wawsat);

    lvl = LVL_NONE;
    if (flush)             lvl = LVL_NONE;
    else if (stallreq_mem) lvl = LVL_MEM;
    else if (stallreq_ex)  lvl = LVL_EX;
    else if (stallreq_id)  lvl = LVL_ID;
    stall = STALL_W'(stall_mask(lvl));

    issue = issue_base && !stall[3] && !stallreq_id;
  end

  always_comb begin
    run_next = run_reg;
    if (flush || (stall == '0))
      run_next = '0;
    else if (run_reg != {RUN_W{1'b1}})
      run_next = run_reg + RUN_W'(1);

    timeout_next = timeout_reg || (run_reg == RUN_W'(STALL_TO - 1));

    hazard_next = hazard_reg;
    if (stallreq_id && (hazard_reg != {PERF_W{1'b1}}))
      hazard_next = hazard_reg + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_reg     <= '0;
      timeout_reg <= 1'b0;
      hazard_reg  <= '0;
    end else begin
      run_reg     <= run_next;
      timeout_reg <= timeout_next;
      hazard_reg  <= hazard_next;
    end
  end

  assign stall_timeout = timeout_reg;
  assign hazard_cnt    = hazard_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: the driver queues the expected
// outputs for each cycle, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        id_rf_we;
  logic [4:0]  id_rd;
  logic        id_long;
  logic        ret_valid;
  logic [4:0]  ret_rd;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [5:0]  stall;
  logic        stallreq_id;
  logic        stall_timeout;
  logic [31:0] hazard_cnt;

  localparam logic [5:0] S0   = 6'b000000;
  localparam logic [5:0] S_ID = 6'b000111;
  localparam logic [5:0] S_EX = 6'b001111;
  localparam logic [5:0] S_MM = 6'b011111;

  typedef struct {
    string      name;
    logic [5:0] stall;
    logic       sreq;
    int         cnt;
    int         to;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .STALL_W  (6),
    .CNT_W    (2),
    .STALL_TO (1024),
    .PERF_W   (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .id_rf_we      (id_rf_we),
    .id_rd         (id_rd),
    .id_long       (id_long),
    .ret_valid     (ret_valid),
    .ret_rd        (ret_rd),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .stall         (stall),
    .stallreq_id   (stallreq_id),
    .stall_timeout (stall_timeout),
    .hazard_cnt    (hazard_cnt)
  );

  // Monitor: one comparison line per transaction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (stall !== e.stall) begin
        n_fail++;
        $display("FAIL %s stall: got %b want %b", e.name, stall, e.stall);
      end
      n_checks++;
      if (stallreq_id !== e.sreq) begin
        n_fail++;
        $display("FAIL %s stallreq_id: got %b want %b", e.name, stallreq_id, e.sreq);
      end
      if (e.cnt >= 0) begin
        n_checks++;
        if (hazard_cnt !== 32'(e.cnt)) begin
          n_fail++;
          $display("FAIL %s hazard_cnt: got %0d want %0d", e.name, hazard_cnt, e.cnt);
        end
      end
      if (e.to >= 0) begin
        n_checks++;
        if (stall_timeout !== 1'(e.to)) begin
          n_fail++;
          $display("FAIL %s stall_timeout: got %b want %0d", e.name, stall_timeout, e.to);
        end
      end
      $display("txn %-14s stall=%b sreq=%b hcnt=%0d to=%b", e.name, stall, stallreq_id,
               hazard_cnt, stall_timeout);
    end
  end

  task automatic idle();
    flush = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rf_we = 0; id_rd = 0; id_long = 0; ret_valid = 0; ret_rd = 0;
    stallreq_ex = 0; stallreq_mem = 0;
  endtask

  task automatic long_wr(input logic [4:0] rd);
    id_valid = 1; id_rf_we = 1; id_long = 1; id_rd = rd;
  endtask

  task automatic rd_rs1(input logic [4:0] rs);
    id_valid = 1; id_use_rs1 = 1; id_rs1 = rs;
  endtask

  task automatic rd_rs2(input logic [4:0] rs);
    id_valid = 1; id_use_rs2 = 1; id_rs2 = rs;
  endtask

  task automatic retire(input logic [4:0] rd);
    ret_valid = 1; ret_rd = rd;
  endtask

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic go(input string nm, input logic [5:0] st, input logic sr,
                    input int cnt, input int to);
    exp_t e;
    e.name = nm; e.stall = st; e.sreq = sr; e.cnt = cnt; e.to = to;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish by 200000");
    $fatal(1, "bench timeout");
  end

  initial begin
    idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    go("reset", S0, 0, 0, 0);

    // Load-use with release through the retire bypass
    long_wr(5);                      go("ld5_issue", S0, 0, 0, 0);
    rd_rs1(5);                       go("ld5_use1", S_ID, 1, 0, 0);
    rd_rs1(5);                       go("ld5_use2", S_ID, 1, 1, -1);
    rd_rs1(5); retire(5);            go("ld5_bypass", S0, 0, 2, -1);
    rd_rs1(5);                       go("ld5_after", S0, 0, 2, -1);

    // Back-to-back divides to rd=7
    long_wr(7);                      go("div7_a", S0, 0, 2, -1);
    long_wr(7);                      go("div7_b", S0, 0, 2, -1);
    rd_rs2(7); retire(7);            go("div7_ret1", S_ID, 1, 2, -1);
    rd_rs2(7);                       go("div7_pend1", S_ID, 1, 3, -1);
    rd_rs2(7); retire(7);            go("div7_ret2", S0, 0, 4, -1);
    rd_rs2(7);                       go("div7_clear", S0, 0, 4, -1);

    // Saturation of rd=9
    long_wr(9);                      go("sat9_1", S0, 0, 4, -1);
    long_wr(9);                      go("sat9_2", S0, 0, 4, -1);
    long_wr(9);                      go("sat9_3", S0, 0, 4, -1);
    long_wr(9);                      go("sat9_4", S_ID, 1, 4, -1);
    rd_rs1(9); retire(9);            go("sat9_r3", S_ID, 1, 5, -1);
    rd_rs1(9); retire(9);            go("sat9_r2", S_ID, 1, 6, -1);
    rd_rs1(9); retire(9);            go("sat9_r1", S0, 0, 7, -1);
    rd_rs1(9);                       go("sat9_zero", S0, 0, 7, -1);

    // Priority and flush
    long_wr(10);                     go("pri_issue", S0, 0, 7, -1);
    rd_rs1(10); stallreq_mem = 1; stallreq_ex = 1;
                                     go("pri_all", S_MM, 1, 7, -1);
    rd_rs1(10); stallreq_mem = 1; stallreq_ex = 1; flush = 1;
                                     go("pri_flush", S0, 1, 8, -1);
    rd_rs1(10);                      go("flush_clr", S0, 0, 9, -1);
    stallreq_ex = 1;                 go("pri_ex", S_EX, 0, 9, -1);
    stallreq_mem = 1;                go("pri_mem", S_MM, 0, 9, -1);

    // x0 and same-cycle issue/retire
    long_wr(0);                      go("x0_wr", S0, 0, 9, -1);
    long_wr(0); rd_rs1(0);           go("x0_rd", S0, 0, 9, -1);
    long_wr(3);                      go("r3_issue", S0, 0, 9, -1);
    long_wr(3); retire(3);           go("r3_both", S0, 0, 9, -1);
    rd_rs1(3);                       go("r3_pend1", S_ID, 1, 9, -1);
    rd_rs1(3); retire(3);            go("r3_bypass", S0, 0, 10, -1);
    rd_rs1(3);                       go("r3_zero", S0, 0, 10, -1);

    // Retire at zero must not underflow
    retire(12);                      go("uf_ret0", S0, 0, 10, -1);
    long_wr(12);                     go("uf_issue", S0, 0, 10, -1);
    rd_rs1(12); retire(12);          go("uf_bypass", S0, 0, 10, -1);
    rd_rs1(12);                      go("uf_zero", S0, 0, 10, 0);

    // Watchdog: exactly 1024 consecutive stalled cycles
    stallreq_ex = 1;
    repeat (1023) @(posedge clk);
    #1;
    stallreq_ex = 1;                 go("wd_edge", S_EX, 0, 10, 0);
                                     go("wd_fire", S0, 0, 10, 1);
                                     go("wd_sticky", S0, 0, 10, 1);

    // Reset in the middle of a stall
    long_wr(14);                     go("rst_pre", S0, 0, 10, 1);
    rd_rs1(14); stallreq_ex = 1; rst_n = 0;
                                     go("rst_mid", S_EX, 1, 10, 1);
    rst_n = 1; rd_rs1(14);           go("rst_after", S0, 0, 0, 0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
